// File: rtl/sw_scan_if.sv
// Event stream between the switch scanner and its consumer.
interface sw_scan_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [4:0] ev_data;   // {kind, idx[3:0]}; kind 1 = press, 0 = release
  logic       ev_lost;

  modport master (output ev_valid, output ev_data, output ev_lost, input ev_ready);
  modport slave  (input ev_valid, input ev_data, input ev_lost, output ev_ready);
endinterface

// File: rtl/sw_scan.sv
// 16-switch debouncer with press/release event queue.
// Each lane synchronizes, samples on the shared tick, debounces and holds a
// pending press/release flag; the top arbitrates pending flags into a
// 4-entry event FIFO.

module sw_scan_lane #(
  parameter int STABLE_N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  input  logic tick_i,
  input  logic grant_i,       // pending flag of this lane pushed this cycle
  output logic state_o,
  output logic press_pend_o,
  output logic rel_pend_o,
  output logic lost_o         // an event was coalesced away this cycle
);
  logic                sync1_q, sync2_q;
  logic [STABLE_N-1:0] hist_q, hist_d;
  logic                state_q, state_d;
  logic                press_pend_q, press_pend_d;
  logic                rel_pend_q, rel_pend_d;
  logic                press_ev, rel_ev;

  // History shift, acceptance, and pending-flag update with coalescing.
  // Both flags are never set together, so a grant clears whichever one is set.
  always_comb begin
    hist_d       = hist_q;
    state_d      = state_q;
    press_ev     = 1'b0;
    rel_ev       = 1'b0;
    press_pend_d = press_pend_q & ~grant_i;
    rel_pend_d   = rel_pend_q & ~grant_i;
    lost_o       = 1'b0;
    if (tick_i) begin
      hist_d = {hist_q[STABLE_N-2:0], sync2_q};
      if ((&hist_d) && !state_q) begin
        state_d  = 1'b1;
        press_ev = 1'b1;
      end else if (!(|hist_d) && state_q) begin
        state_d = 1'b0;
        rel_ev  = 1'b1;
      end
    end
    if (press_ev) begin
      if (rel_pend_d) begin
        rel_pend_d = 1'b0;
        lost_o     = 1'b1;
      end else begin
        press_pend_d = 1'b1;
      end
    end
    if (rel_ev) begin
      if (press_pend_d) begin
        press_pend_d = 1'b0;
        lost_o       = 1'b1;
      end else begin
        rel_pend_d = 1'b1;
      end
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hist_q       <= '0;
      state_q      <= 1'b0;
      press_pend_q <= 1'b0;
      rel_pend_q   <= 1'b0;
    end else begin
      sync1_q      <= sw_i;
      sync2_q      <= sync1_q;
      hist_q       <= hist_d;
      state_q      <= state_d;
      press_pend_q <= press_pend_d;
      rel_pend_q   <= rel_pend_d;
    end
  end

  assign state_o      = state_q;
  assign press_pend_o = press_pend_q;
  assign rel_pend_o   = rel_pend_q;
endmodule

module sw_scan #(
  parameter int TICK_DIV = 50000,
  parameter int STABLE_N = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw_i,
  output logic [15:0] sw_state_o,
  sw_scan_if.master   ev
);
  localparam int NUM_LANES = 16;
  localparam int IW        = 4;
  localparam int CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0]          div_q, div_d;
  logic                   tick;
  logic [NUM_LANES-1:0]   press_pend, rel_pend, req, grant, lost_vec;
  logic                   found, push, pop, full;
  logic [IW-1:0]          sel;
  logic [4:0]             push_data;
  logic [3:0][4:0]        mem_q;
  logic [1:0]             wr_q, wr_d, rd_q, rd_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   lost_q;

  // Sample-tick prescaler: one tick per TICK_DIV cycles.
  always_comb begin
    tick  = (div_q == CW'(TICK_DIV - 1));
    div_d = tick ? '0 : div_q + CW'(1);
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sw_scan_lane #(.STABLE_N(STABLE_N)) u_lane (
      .clk          (clk),
      .rst          (rst),
      .sw_i         (sw_i[g]),
      .tick_i       (tick),
      .grant_i      (grant[g]),
      .state_o      (sw_state_o[g]),
      .press_pend_o (press_pend[g]),
      .rel_pend_o   (rel_pend[g]),
      .lost_o       (lost_vec[g])
    );
  end

  // Lowest-index pending lane wins; push only when the FIFO can take it.
  always_comb begin
    req   = press_pend | rel_pend;
    found = 1'b0;
    sel   = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
    pop       = ev.ev_valid & ev.ev_ready;
    full      = (cnt_q == 3'd4);
    push      = found & (!full | pop);
    grant     = push ? (NUM_LANES'(1) << sel) : '0;
    push_data = {press_pend[sel], sel};
  end

  // FIFO pointer/occupancy next state; pointers wrap naturally at 4.
  always_comb begin
    wr_d  = wr_q + 2'(push);
    rd_d  = rd_q + 2'(pop);
    cnt_d = cnt_q + 3'(push) - 3'(pop);
  end

  // Prescaler, FIFO storage and sticky lost flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      mem_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      lost_q <= 1'b0;
    end else begin
      div_q <= div_d;
      if (push) mem_q[wr_q] <= push_data;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      lost_q <= lost_q | (|lost_vec);
    end
  end

  assign ev.ev_valid = (cnt_q != 3'd0);
  assign ev.ev_data  = mem_q[rd_q];
  assign ev.ev_lost  = lost_q;
endmodule

// File: doc/sw_scan.md
SW_SCAN -- requirements
Module: sw_scan

Interface
REQ-001 The block SHALL have these parameters:
- TICK_DIV, default 50000, meaning clk cycles per sample tick (minimum 2).
- STABLE_N, default 4, meaning consecutive equal samples required to accept a level (minimum 2).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports are listed clock and reset first:
- clk  input  1  sole clock.
- rst  input  1  synchronous active-high reset.
- sw  input  16  raw asynchronous switch levels.
- sw_state  output  16  debounced switch levels.
- ev_valid  output  1  event available at the head of the queue.
- ev_ready  input  1  consumer accepts the head event.
- ev_data  output  5  {kind, idx[3:0]}, where kind 1 = press (0->1) and kind 0 = release (1->0).
- ev_lost  output  1  sticky flag: an event was coalesced away.

Function
REQ-003 Each sw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-004 Prescaler: counts 0..TICK_DIV-1, wraps to 0, and asserts an internal tick for the one cycle where count == TICK_DIV-1.
REQ-005 On each tick, every bit SHALL shift its synchronized level into a STABLE_N-deep history; bits are not sampled between ticks.
REQ-006 Acceptance rule, evaluated after the shift on the same tick:
- History all 1 and sw_state bit 0: the sw_state bit SHALL become 1 and a press event SHALL be raised for that bit.
- History all 0 and sw_state bit 1: the bit SHALL become 0 and a release event SHALL be raised.
- Any other history: no change.
REQ-007 A raised event SHALL set a per-bit pending flag of its kind (press_pend or rel_pend) in the cycle after the tick.
REQ-008 Coalescing: if an event is raised for a bit that still holds the opposite pending flag, both flags for that bit SHALL clear, no event is queued, and ev_lost SHALL set.
REQ-009 Arbiter: each cycle, the lowest-index bit holding a pending flag SHALL be pushed into the queue and its flag cleared, provided the queue can accept. At most one push occurs per cycle.
REQ-010 Queue: synchronous FIFO, 4 entries of 5 bits.
- ev_valid = not empty; ev_data = head entry.
- A pop occurs on any cycle with ev_valid and ev_ready both high.
REQ-011 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle. Simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-012 A rejected push SHALL leave the pending flag set, so the event is retried on later cycles. Events are never dropped except by REQ-008.
REQ-013 ev_valid and ev_data SHALL stay stable while ev_valid is high and ev_ready is low.
REQ-014 Latency:
- Raw sw edge to sw_state change: 2 synchronizer cycles plus at most STABLE_N ticks.
- Tick to pending flag set: 1 cycle.
- Pending to push: at least 1 cycle.
- Push to ev_valid, when the FIFO was empty: 1 cycle.
REQ-015 FIFO pointers SHALL wrap modulo 4. The prescaler SHALL be wide enough for TICK_DIV-1 and SHALL wrap without overflow.
REQ-016 ev_lost SHALL stay set until reset. No input clears it.

Reset
REQ-017 While rst is high at a clk edge, the block SHALL reset these state elements, and all outputs SHALL read 0 from the following cycle:
- synchronizer flops, histories, prescaler, sw_state, pending flags, FIFO pointers and contents, ev_lost.
REQ-018 Reset asserted mid-operation SHALL discard queued and pending events immediately; no event from before reset SHALL appear after it.
REQ-019 Switches high at reset release SHALL produce press events through the normal debounce path, since sw_state starts at 0.

Verification
(TICK_DIV=4, STABLE_N=3 unless stated.)
REQ-020 The bench SHALL cover the following directed scenarios:
- Single press: sw[5] 0->1 and held, ev_ready=1 -> sw_state[5]=1 within 2+12 cycles; exactly one ev_data=5'b1_0101; ev_valid high for 1 cycle.
- Bounce: sw[0] toggles every 3 cycles for 40 cycles, then holds 1 -> no event during the toggling; one press 5'b1_0000 after the hold is debounced.
- Simultaneous press: sw = 16'h8001 in one cycle, ev_ready=1 -> events 5'b1_0000 then 5'b1_1111, on consecutive valid cycles.
- Backpressure: ev_ready=0; sw[0..5] pressed together -> 4 entries queued; ev_valid held with head 5'b1_0000; 2 flags left pending. Then ev_ready=1 -> 6 events in index order 0..5 with none lost; ev_lost=0.
- Coalesce: ev_ready=0 and the FIFO pre-filled with 4 events; sw[9] pressed, then released and held low -> no bit-9 event ever queued; ev_lost=1 and stays 1.
- Reset mid-queue: 3 events queued, then rst for 1 cycle -> the next cycle has ev_valid=0, sw_state=0, ev_lost=0; with sw still high, presses re-emerge after debounce.
